// File: rtl/zx_contention_ctrl_pkg.sv
// zx_contention_ctrl_pkg: shared ULA timing constants, contended window bounds and FSM state type
package zx_contention_ctrl_pkg;
  localparam int DIV_DEF = 8;
  localparam int LINES_DEF = 312;
  localparam int TPL_DEF = 224;
  localparam int WIN_LINE_LO = 64;
  localparam int WIN_LINE_HI = 255;
  localparam int WIN_TS_HI = 127;
  localparam int IRQ_LEN = 32;
  typedef enum logic {IDLE, ACTIVE} state_e;
endpackage

// File: rtl/zx_timebase.sv
// zx_timebase: master clock divider, line/T-state frame counters and registered frame interrupt
module zx_timebase
  import zx_contention_ctrl_pkg::*;
#(
  parameter int DIV = DIV_DEF,
  parameter int LINES = LINES_DEF,
  parameter int TPL = TPL_DEF
) (
  input  logic       clock,
  input  logic       reset,
  output logic       tick_o,
  output logic       half_o,
  output logic [8:0] line_o,
  output logic [7:0] tstate_o,
  output logic [8:0] line_n_o,
  output logic [7:0] tstate_n_o,
  output logic       irq_o
);
  localparam int DW = $clog2(DIV);
  logic [DW-1:0] div_q, div_d;
  logic [8:0] line_q, line_d;
  logic [7:0] tstate_q, tstate_d;
  logic irq_q, ts_end, ln_end;
  always_comb begin
    tick_o = div_q == DW'(DIV - 1);
    half_o = div_q == DW'(DIV / 2 - 1);
    ts_end = tstate_q == 8'(TPL - 1);
    ln_end = line_q == 9'(LINES - 1);
    div_d = tick_o ? '0 : div_q + 1'b1;
    tstate_d = !tick_o ? tstate_q : ts_end ? '0 : tstate_q + 1'b1;
    line_d = !(tick_o && ts_end) ? line_q : ln_end ? '0 : line_q + 1'b1;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      div_q <= '0;
      line_q <= '0;
      tstate_q <= '0;
      irq_q <= 1'b1;
    end else begin
      div_q <= div_d;
      line_q <= line_d;
      tstate_q <= tstate_d;
      irq_q <= !(line_q == '0 && tstate_q < 8'(IRQ_LEN));
    end
  end
  assign line_o = line_q;
  assign tstate_o = tstate_q;
  assign line_n_o = line_d;
  assign tstate_n_o = tstate_d;
  assign irq_o = irq_q;
endmodule

// File: rtl/zx_contention_ctrl.sv
// zx_contention_ctrl: CPU clock enables, frame interrupt and 48K-style memory/IO contention stalls
module zx_contention_ctrl
  import zx_contention_ctrl_pkg::*;
#(
  parameter int DIV = DIV_DEF,
  parameter int LINES = LINES_DEF,
  parameter int TPL = TPL_DEF,
  parameter int CONTEND = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] a,
  input  logic        mreq,
  input  logic        iorq,
  input  logic        rfsh,
  output logic        ne,
  output logic        pe,
  output logic        irq,
  output logic [8:0]  line,
  output logic [7:0]  tstate,
  output logic        hold
);
  state_e state_q, state_d;
  logic run_q, run_d, pe_q, ne_q, hold_q;
  logic tick, half, acc, win, stall, unused_a;
  logic [8:0] line_n;
  logic [7:0] tstate_n;
  zx_timebase #(.DIV(DIV), .LINES(LINES), .TPL(TPL)) u_timebase (
    .clock      (clock),
    .reset      (reset),
    .tick_o     (tick),
    .half_o     (half),
    .line_o     (line),
    .tstate_o   (tstate),
    .line_n_o   (line_n),
    .tstate_n_o (tstate_n),
    .irq_o      (irq)
  );
  // Contention is judged against the T-state that begins at this tick
  always_comb begin
    unused_a = ^a[13:1];
    acc = rfsh && ((!mreq && a[15:14] == 2'b01) || (!iorq && !a[0]));
    win = CONTEND != 0 && line_n >= 9'(WIN_LINE_LO) && line_n <= 9'(WIN_LINE_HI)
          && tstate_n <= 8'(WIN_TS_HI);
    stall = tick && state_q == IDLE && acc && win && tstate_n[2:0] < 3'd6;
    state_d = (!tick || stall) ? state_q : acc ? ACTIVE : IDLE;
    run_d = tick ? !stall : run_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      run_q <= 1'b0;
      pe_q <= 1'b0;
      ne_q <= 1'b0;
      hold_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q <= run_d;
      pe_q <= tick && !stall;
      ne_q <= half && run_q;
      hold_q <= tick ? stall : hold_q;
    end
  end
  assign pe = pe_q;
  assign ne = ne_q;
  assign hold = hold_q;
endmodule

// File: tb/tb_zx_contention_ctrl.sv
// tb_zx_contention_ctrl: checks timebase, irq, enables and contention delays against an arithmetic model
module tb_zx_contention_ctrl;
  localparam int DIV = 4, TPL = 136, LINES = 312, TPL1 = 40, LINES1 = 3;
  logic clock = 1'b0, reset = 1'b1;
  logic [15:0] a = 16'h0;
  logic mreq = 1'b1, iorq = 1'b1, rfsh = 1'b1;
  logic ne, pe, irq, hold, ne1, pe1, irq1, hold1;
  logic [8:0] line, line1;
  logic [7:0] tstate, tstate1;
  int vec = 0, err = 0, k = 0;
  bit mon = 0;

  zx_contention_ctrl #(.DIV(DIV), .LINES(LINES), .TPL(TPL), .CONTEND(1)) dut (
    .clock(clock), .reset(reset), .a(a), .mreq(mreq), .iorq(iorq), .rfsh(rfsh),
    .ne(ne), .pe(pe), .irq(irq), .line(line), .tstate(tstate), .hold(hold));
  zx_contention_ctrl #(.DIV(DIV), .LINES(LINES1), .TPL(TPL1), .CONTEND(0)) u1 (
    .clock(clock), .reset(reset), .a(a), .mreq(mreq), .iorq(iorq), .rfsh(rfsh),
    .ne(ne1), .pe(pe1), .irq(irq1), .line(line1), .tstate(tstate1), .hold(hold1));

  always #5 clock = ~clock;
  always @(posedge clock) k <= reset ? 0 : k + 1;

  function automatic int ln(int kk, int tpl, int lines);
    return (kk / DIV / tpl) % lines;
  endfunction
  function automatic int ts(int kk, int tpl);
    return (kk / DIV) % tpl;
  endfunction
  function automatic logic irq_m(int kk, int tpl, int lines);
    return kk == 0 ? 1'b1 : !(ln(kk - 1, tpl, lines) == 0 && ts(kk - 1, tpl) < 32);
  endfunction
  function automatic int delay_m(int l, int t, logic m, logic io, logic rf, logic [15:0] ad);
    bit acc_m, win_m;
    acc_m = rf && ((!m && ad[15:14] == 2'b01) || (!io && !ad[0]));
    win_m = l >= 64 && l <= 255 && t <= 127;
    return (acc_m && win_m && t % 8 < 6) ? 6 - t % 8 : 0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) if (mon) begin
    chk("line", line, ln(k, TPL, LINES));
    chk("tstate", tstate, ts(k, TPL));
    chk("irq", irq, irq_m(k, TPL, LINES));
    chk("pe_ne_excl", pe && ne, 0);
    chk("ne_in_hold", ne && hold, 0);
    chk("u1_line", line1, ln(k, TPL1, LINES1));
    chk("u1_tstate", tstate1, ts(k, TPL1));
    chk("u1_irq", irq1, irq_m(k, TPL1, LINES1));
    chk("u1_pe", pe1, k % DIV == 0 && k >= DIV);
    chk("u1_ne", ne1, k % DIV == DIV / 2 && k > DIV);
    chk("u1_hold", hold1, 0);
  end

  // Present an access just before the tick that enters T-state index x, then count withheld pe pulses
  task automatic probe(string tag, int x, logic m, logic io, logic rf, logic [15:0] ad);
    int stalls = 0, hc = 0, d;
    bit got = 0;
    d = delay_m(x / TPL, x % TPL, m, io, rf, ad);
    while (k < (x - 1) * DIV) @(negedge clock);
    mreq = m; iorq = io; rfsh = rf; a = ad;
    for (int j = 0; j < 10 && !got; j++) begin
      repeat (DIV) begin
        @(negedge clock);
        hc += int'(hold);
      end
      if (pe) got = 1; else stalls++;
    end
    mreq = 1'b1; iorq = 1'b1; rfsh = 1'b1; a = 16'h0;
    chk({tag, "_granted"}, 32'(got), 1);
    chk({tag, "_stalls"}, stalls, d);
    chk({tag, "_hold"}, hc, DIV * d);
  endtask

  initial begin
    int x, kind;
    logic m, io, rf;
    logic [15:0] ad;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    mon = 1;
    chk("rst_pe", pe, 0);
    chk("rst_ne", ne, 0);
    chk("rst_hold", hold, 0);
    chk("rst_irq", irq, 1);
    chk("rst_line", line, 0);
    chk("rst_tstate", tstate, 0);
    probe("line63", 63 * TPL, 0, 1, 1, 16'h4000);
    probe("grp0", 64 * TPL, 0, 1, 1, 16'h4000);
    probe("grp6", 64 * TPL + 14, 0, 1, 1, 16'h4000);
    probe("a8000", 64 * TPL + 20, 0, 1, 1, 16'h8000);
    probe("io_fe", 64 * TPL + 27, 1, 0, 1, 16'h00FE);
    probe("io_ff", 64 * TPL + 40, 1, 0, 1, 16'h00FF);
    probe("rfsh", 64 * TPL + 50, 0, 1, 0, 16'h4000);
    probe("grp4_late", 64 * TPL + 124, 0, 1, 1, 16'h4000);
    probe("ts130", 64 * TPL + 130, 0, 1, 1, 16'h4000);
    probe("ts6", 65 * TPL + 6, 0, 1, 1, 16'h4000);
    x = 65 * TPL + 20;
    for (int i = 0; i < 12; i++) begin
      kind = int'($urandom % 4);
      m = 1'b1; io = 1'b1; rf = 1'b1; ad = 16'($urandom);
      if (kind == 0 || kind == 3) begin
        m = 1'b0;
        ad[15:14] = 2'b01;
        rf = kind != 3;
      end else if (kind == 1) begin
        m = 1'b0;
        if (ad[15:14] == 2'b01) ad[15] = 1'b1;
      end else io = 1'b0;
      probe("rand", x, m, io, rf, ad);
      x += 12 + int'($urandom % 16);
    end
    x = 68 * TPL;
    while (k < (x - 1) * DIV) @(negedge clock);
    mreq = 1'b0; a = 16'h4000;
    while (k < (x + 2) * DIV + 1) @(negedge clock);
    chk("midstall_hold", hold, 1);
    chk("midstall_pe", pe, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; mreq = 1'b1; a = 16'h0;
    chk("rst2_pe", pe, 0);
    chk("rst2_ne", ne, 0);
    chk("rst2_hold", hold, 0);
    chk("rst2_irq", irq, 1);
    chk("rst2_line", line, 0);
    chk("rst2_tstate", tstate, 0);
    repeat (3 * DIV) @(negedge clock);
    mon = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
